// File: rtl/matrix_display_reader.sv
// -----------------------------------------------------------------------------
// MatrixDisplayReader
//
// Streams one stored matrix out of the matrix storage block and prints it as
// ASCII text through a byte-wide UART transmitter.
//
// Each element is printed as a signed decimal number. A space follows every
// element except the last one in a row, which is followed by a line feed.
// Elements are requested from storage one at a time. Characters are handed to
// the transmitter one at a time, and the block honours the transmitter's busy
// handshake.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   disp_req_i                   one-cycle print request
//   disp_id_i                    slot to print, sampled with the request
//   disp_m_i, disp_n_i           row and column count of that slot
//   start_disp_o                 opens the read stream in storage
//   matrix_id_sel_o              slot id shown to storage
//   read_en_o                    fetch-next-element pulse
//   meta_info_valid_i            storage accepted the stream
//   st_error_i                   storage rejected the slot
//   elem_data_i, elem_valid_i    returned element, signed 8-bit
//   tx_data_o, tx_start_o        character and send strobe to the UART
//   tx_busy_i                    UART still shifting a character
//   busy_o, done_o, err_o        status: active, finished, aborted
// -----------------------------------------------------------------------------
module matrix_display_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_req_i,
    input  logic [3:0] disp_id_i,
    input  logic [2:0] disp_m_i,
    input  logic [2:0] disp_n_i,
    output logic       start_disp_o,
    output logic [3:0] matrix_id_sel_o,
    output logic       read_en_o,
    input  logic       meta_info_valid_i,
    input  logic       st_error_i,
    input  logic [7:0] elem_data_i,
    input  logic       elem_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_start_o,
    input  logic       tx_busy_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [3:0] {
        IDLE,
        OPEN,
        WAIT_META,
        REQ,
        WAIT_DATA,
        CONV,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t     state_q;
    logic [2:0] rows_q;
    logic [2:0] cols_q;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [2:0] timer_q;
    logic [7:0] elem_q;
    logic [7:0] charBuf_q [5];
    logic [2:0] charCnt_q;
    logic [2:0] charIdx_q;

    logic       startDisp_q;
    logic       readEn_q;
    logic       txStart_q;
    logic [7:0] txData_q;
    logic [3:0] idSel_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;

    logic [7:0] charBuf_d [5];
    logic [2:0] charCnt_d;
    logic       elemNeg;
    logic [7:0] elemMag;
    logic [7:0] hundreds;
    logic [7:0] tens;
    logic [7:0] ones;
    logic [7:0] sepChar;
    logic       dimsOk;

    assign start_disp_o    = startDisp_q;
    assign read_en_o       = readEn_q;
    assign tx_start_o      = txStart_q;
    assign tx_data_o       = txData_q;
    assign matrix_id_sel_o = idSel_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

    // Only 1..5 rows and columns can be stored, so anything else is refused.
    assign dimsOk = (disp_m_i != 3'd0) && (disp_m_i <= 3'd5) &&
                    (disp_n_i != 3'd0) && (disp_n_i <= 3'd5);

    // Turns the captured element into its character sequence.
    // The magnitude is taken in 8-bit unsigned arithmetic, so -128 (0x80)
    // negates to 0x80 and prints as 128 without overflowing.
    // Characters are appended left to right. The write index doubles as the
    // final character count, which is at most 5: "-128" plus a separator.
    always_comb begin
        elemNeg  = elem_q[7];
        elemMag  = elemNeg ? (~elem_q + 8'd1) : elem_q;
        hundreds = elemMag / 8'd100;
        tens     = (elemMag % 8'd100) / 8'd10;
        ones     = elemMag % 8'd10;
        sepChar  = (col_q == cols_q - 3'd1) ? 8'h0A : 8'h20;
        for (int i = 0; i < 5; i++) begin
            charBuf_d[i] = 8'h00;
        end
        charCnt_d = 3'd0;
        if (elemNeg) begin
            charBuf_d[charCnt_d] = 8'h2D;
            charCnt_d            = charCnt_d + 3'd1;
        end
        if (hundreds != 8'd0) begin
            charBuf_d[charCnt_d] = 8'h30 + hundreds;
            charCnt_d            = charCnt_d + 3'd1;
        end
        if ((hundreds != 8'd0) || (tens != 8'd0)) begin
            charBuf_d[charCnt_d] = 8'h30 + tens;
            charCnt_d            = charCnt_d + 3'd1;
        end
        charBuf_d[charCnt_d] = 8'h30 + ones;
        charCnt_d            = charCnt_d + 3'd1;
        charBuf_d[charCnt_d] = sepChar;
        charCnt_d            = charCnt_d + 3'd1;
    end

    // Main sequencer. Every output is registered here.
    // The strobes (start, read, tx, done, err) default low each cycle, so each
    // one lasts exactly one cycle.
    // Both wait states share one 3-bit timer. An abort fires on the eighth
    // silent cycle, counting the cycle the request strobe is visible.
    // GAP exists so the transmitter's busy flag, which rises one cycle after
    // tx_start, is already high when SEND looks at it again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rows_q      <= 3'd0;
            cols_q      <= 3'd0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            timer_q     <= 3'd0;
            elem_q      <= 8'h00;
            charCnt_q   <= 3'd0;
            charIdx_q   <= 3'd0;
            startDisp_q <= 1'b0;
            readEn_q    <= 1'b0;
            txStart_q   <= 1'b0;
            txData_q    <= 8'h00;
            idSel_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                charBuf_q[i] <= 8'h00;
            end
        end else begin
            startDisp_q <= 1'b0;
            readEn_q    <= 1'b0;
            txStart_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (disp_req_i) begin
                        if (dimsOk) begin
                            idSel_q <= disp_id_i;
                            rows_q  <= disp_m_i;
                            cols_q  <= disp_n_i;
                            row_q   <= 3'd0;
                            col_q   <= 3'd0;
                            busy_q  <= 1'b1;
                            state_q <= OPEN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                OPEN: begin
                    startDisp_q <= 1'b1;
                    timer_q     <= 3'd0;
                    state_q     <= WAIT_META;
                end
                WAIT_META: begin
                    if (st_error_i || (!meta_info_valid_i && timer_q == 3'd7)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        idSel_q <= 4'd0;
                        state_q <= IDLE;
                    end else if (meta_info_valid_i) begin
                        state_q <= REQ;
                    end else begin
                        timer_q <= timer_q + 3'd1;
                    end
                end
                REQ: begin
                    readEn_q <= 1'b1;
                    timer_q  <= 3'd0;
                    state_q  <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (elem_valid_i) begin
                        elem_q  <= elem_data_i;
                        state_q <= CONV;
                    end else if (timer_q == 3'd7) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        idSel_q <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 3'd1;
                    end
                end
                CONV: begin
                    charBuf_q <= charBuf_d;
                    charCnt_q <= charCnt_d;
                    charIdx_q <= 3'd0;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (!tx_busy_i) begin
                        txData_q  <= charBuf_q[charIdx_q];
                        txStart_q <= 1'b1;
                        charIdx_q <= charIdx_q + 3'd1;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (charIdx_q != charCnt_q) begin
                        state_q <= SEND;
                    end else if (col_q == cols_q - 3'd1) begin
                        col_q <= 3'd0;
                        if (row_q == rows_q - 3'd1) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q   <= row_q + 3'd1;
                            state_q <= REQ;
                        end
                    end else begin
                        col_q   <= col_q + 3'd1;
                        state_q <= REQ;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    idSel_q <= 4'd0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
